// File: rtl/spart_word_link_pkg.sv
// Shared types and defaults for the word-to-byte framing between the processor and spart.
// Byte order on the serial link is little-endian: byte 0 travels first.
package spart_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

  localparam int BYTES_PER_WORD      = 4;
  localparam int DEFAULT_BYTE_CYCLES = 52100;
  localparam int DEFAULT_RX_TIMEOUT  = 208400;

  function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/spart_word_rx.sv
// Receive side: detects spart_rda rising edges, assembles four bytes into a word,
// and drops a partial word that stalls for RX_TIMEOUT cycles.
module spart_word_rx
  import spart_link_pkg::*;
#(
  parameter int RX_TIMEOUT = DEFAULT_RX_TIMEOUT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        spart_rda,
  input  logic [7:0]  spart_rxdata,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        rx_err
);

  localparam int          TW        = $clog2(RX_TIMEOUT + 1);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic          rdaQ_q;
  logic [1:0]    idx_q;
  logic [31:0]   lanes_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   rxData_q;
  logic          rxValid_q;
  logic          rxErr_q;
  logic          byteAccept;
  logic          expire;

  assign byteAccept = spart_rda & ~rdaQ_q;
  assign expire     = (idx_q != 2'd0) && (timer_q == TW'(RX_TIMEOUT - 1));

  // An accepted byte takes priority over a timeout landing in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rdaQ_q    <= 1'b0;
      idx_q     <= 2'd0;
      lanes_q   <= '0;
      timer_q   <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
    end else begin
      rdaQ_q    <= spart_rda;
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
      if (byteAccept) begin
        timer_q <= '0;
        lanes_q[8*idx_q +: 8] <= spart_rxdata;
        if (idx_q == LAST_BYTE) begin
          rxData_q  <= {spart_rxdata, lanes_q[23:0]};
          rxValid_q <= 1'b1;
          idx_q     <= 2'd0;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end else if (expire) begin
        idx_q   <= 2'd0;
        lanes_q <= '0;
        timer_q <= '0;
        rxErr_q <= 1'b1;
      end else if (idx_q != 2'd0) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  assign rx_valid = rxValid_q;
  assign rx_data  = rxData_q;
  assign rx_err   = rxErr_q;

endmodule

// File: rtl/spart_word_link.sv
// Word-level framing stage: TX splits a 32-bit word into four paced spart_txsend strobes,
// RX (in spart_word_rx) rebuilds words from received bytes.
module spart_word_link
  import spart_link_pkg::*;
#(
  parameter int BYTE_CYCLES = DEFAULT_BYTE_CYCLES,
  parameter int RX_TIMEOUT  = DEFAULT_RX_TIMEOUT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        spart_txsend,
  output logic [7:0]  spart_txdata,
  input  logic        spart_rda,
  input  logic [7:0]  spart_rxdata,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        rx_err
);

  localparam int         GW        = $clog2(BYTE_CYCLES);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_t     txState_q, txState_d;
  logic [31:0]   word_q;
  logic [1:0]    byteIdx_q;
  logic [GW-1:0] gapCnt_q;
  logic [7:0]    txByte_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) txState_q <= IDLE;
    else        txState_q <= txState_d;
  end

  always_comb begin
    txState_d = txState_q;
    case (txState_q)
      IDLE:    if (tx_valid) txState_d = SEND;
      SEND:    txState_d = GAP;
      GAP:     if (gapCnt_q == '0) txState_d = (byteIdx_q == LAST_BYTE) ? IDLE : SEND;
      default: txState_d = IDLE;
    endcase
  end

  always_comb begin
    tx_ready     = (txState_q == IDLE);
    spart_txsend = (txState_q == SEND);
  end

  // The outgoing byte is loaded one edge ahead of SEND and then held until the next strobe.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      word_q    <= '0;
      byteIdx_q <= 2'd0;
      gapCnt_q  <= '0;
      txByte_q  <= '0;
    end else begin
      case (txState_q)
        IDLE: begin
          if (tx_valid) begin
            word_q    <= tx_data;
            byteIdx_q <= 2'd0;
            txByte_q  <= tx_data[7:0];
          end
        end
        SEND: gapCnt_q <= GW'(BYTE_CYCLES - 1);
        GAP: begin
          if (gapCnt_q != '0) begin
            gapCnt_q <= gapCnt_q - GW'(1);
          end else if (byteIdx_q != LAST_BYTE) begin
            byteIdx_q <= byteIdx_q + 2'd1;
            txByte_q  <= wordByte(word_q, byteIdx_q + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign spart_txdata = txByte_q;

  spart_word_rx #(
    .RX_TIMEOUT(RX_TIMEOUT)
  ) u_rx (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .spart_rda   (spart_rda),
    .spart_rxdata(spart_rxdata),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_err      (rx_err)
  );

endmodule

// File: tb/tb_spart_word_link.sv
// Bench for spart_word_link: directed and $urandom traffic on both paths, checked against
// an event-level model of when strobes, words and timeouts must appear.
module tb_spart_word_link;

  localparam int BC = 8;
  localparam int RT = 40;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_ready;
  logic        spart_txsend;
  logic [7:0]  spart_txdata;
  logic        spart_rda = 1'b0;
  logic [7:0]  spart_rxdata = '0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_err;

  spart_word_link #(
    .BYTE_CYCLES(BC),
    .RX_TIMEOUT (RT)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .spart_txsend(spart_txsend),
    .spart_txdata(spart_txdata),
    .spart_rda   (spart_rda),
    .spart_rxdata(spart_rxdata),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_err      (rx_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] d;
  } ev_t;

  ev_t obsTx[$];
  ev_t expTx[$];
  ev_t obsRx[$];
  ev_t expRx[$];
  int  obsErr[$];
  int  expErr[$];

  int total = 0;
  int bad = 0;

  // Event recorder: every cycle an output pulse is seen, log it with its cycle number.
  always @(negedge sys_clk) begin
    if (spart_txsend) obsTx.push_back(ev_t'{cyc, {24'h0, spart_txdata}});
    if (rx_valid)     obsRx.push_back(ev_t'{cyc, rx_data});
    if (rx_err)       obsErr.push_back(cyc);
  end

  logic [7:0]  mLanes[$];
  int          mLast = 0;
  logic [31:0] mWord = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // A partial word older than RT cycles has already been dropped with an error pulse.
  task automatic modelAdvance(input int t);
    if (mLanes.size() > 0 && (t - mLast) > RT) begin
      expErr.push_back(mLast + RT);
      mLanes.delete();
    end
  endtask

  task automatic modelAccept(input int t, input logic [7:0] b);
    logic [31:0] w;
    modelAdvance(t);
    mLanes.push_back(b);
    mLast = t;
    if (mLanes.size() == 4) begin
      w = {mLanes[3], mLanes[2], mLanes[1], mLanes[0]};
      expRx.push_back(ev_t'{t, w});
      mWord = w;
      mLanes.delete();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold);
    spart_rxdata = b;
    spart_rda = 1'b1;
    modelAccept(cyc + 1, b);
    step(hold);
    spart_rda = 1'b0;
    step(1);
  endtask

  task automatic waitReady();
    int n = 0;
    while (!tx_ready && n < 1000) begin
      step(1);
      n++;
    end
    checkOutput("tx_ready_wait", {31'h0, tx_ready}, 32'h1);
  endtask

  task automatic startWord(input logic [31:0] w, input bit expect_strobes, output int c0);
    tx_valid = 1'b1;
    tx_data = w;
    c0 = cyc;
    if (expect_strobes)
      for (int k = 0; k < 4; k++)
        expTx.push_back(ev_t'{c0 + 1 + k * (BC + 1), {24'h0, w[8*k +: 8]}});
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic compareQueues();
    checkOutput("tx_strobe_count", 32'(obsTx.size()), 32'(expTx.size()));
    for (int i = 0; i < obsTx.size() && i < expTx.size(); i++) begin
      checkOutput($sformatf("tx_strobe%0d_cycle", i), 32'(obsTx[i].c), 32'(expTx[i].c));
      checkOutput($sformatf("tx_strobe%0d_byte", i), obsTx[i].d, expTx[i].d);
    end
    checkOutput("rx_word_count", 32'(obsRx.size()), 32'(expRx.size()));
    for (int i = 0; i < obsRx.size() && i < expRx.size(); i++) begin
      checkOutput($sformatf("rx_word%0d_cycle", i), 32'(obsRx[i].c), 32'(expRx[i].c));
      checkOutput($sformatf("rx_word%0d_data", i), obsRx[i].d, expRx[i].d);
    end
    checkOutput("rx_err_count", 32'(obsErr.size()), 32'(expErr.size()));
    for (int i = 0; i < obsErr.size() && i < expErr.size(); i++)
      checkOutput($sformatf("rx_err%0d_cycle", i), 32'(obsErr[i]), 32'(expErr[i]));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0;
    int lowCnt;
    logic [31:0] w;

    // Reset values
    step(3);
    checkOutput("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
    checkOutput("reset_txsend", {31'h0, spart_txsend}, 32'h0);
    checkOutput("reset_txdata", {24'h0, spart_txdata}, 32'h0);
    checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("reset_rx_data", rx_data, 32'h0);
    checkOutput("reset_rx_err", {31'h0, rx_err}, 32'h0);
    rst_n = 1'b1;
    step(2);

    // TX word with a busy request during the gap after the 2nd strobe
    waitReady();
    startWord(32'hDEADBEEF, 1'b1, c0);
    lowCnt = 0;
    for (int i = 0; i < 36; i++) begin
      if (!tx_ready) lowCnt++;
      if (cyc == c0 + 14) begin
        tx_valid = 1'b1;
        tx_data = 32'h12345678;
      end else begin
        tx_valid = 1'b0;
      end
      step(1);
    end
    tx_valid = 1'b0;
    checkOutput("tx_ready_low_cycles", 32'(lowCnt), 32'd36);
    checkOutput("tx_ready_after_word", {31'h0, tx_ready}, 32'h1);
    checkOutput("txdata_held_last", {24'h0, spart_txdata}, 32'h0000_00DE);

    // Directed RX word
    applyStimulus(8'h04, 1);
    applyStimulus(8'h03, 1);
    applyStimulus(8'h02, 1);
    applyStimulus(8'h01, 1);
    checkOutput("rx_word_directed", rx_data, 32'h01020304);

    // Timeout on a two-byte partial, rx_data must keep the old word
    applyStimulus(8'hAA, 1);
    applyStimulus(8'hBB, 1);
    step(RT + 5);
    checkOutput("rx_data_held_after_err", rx_data, 32'h01020304);
    applyStimulus(8'h11, 1);
    applyStimulus(8'h22, 1);
    applyStimulus(8'h33, 1);
    applyStimulus(8'h44, 1);
    checkOutput("rx_word_after_err", rx_data, 32'h44332211);

    // Byte edge lands exactly on the timeout cycle
    applyStimulus(8'hAA, 1);
    while (cyc < mLast + RT - 1) step(1);
    applyStimulus(8'hCC, 1);
    applyStimulus(8'($urandom), 1);
    applyStimulus(8'($urandom), 1);
    checkOutput("rx_word_collision", rx_data, mWord);

    // Level held high counts once
    applyStimulus(8'h55, 5);
    applyStimulus(8'($urandom), 1);
    applyStimulus(8'($urandom), 2);
    applyStimulus(8'($urandom), 1);
    checkOutput("rx_word_level", rx_data, mWord);

    // Random RX traffic concurrent with a random TX word, ending on a long idle
    waitReady();
    startWord($urandom, 1'b1, c0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(8'($urandom), $urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) step(RT + $urandom_range(0, 3));
      else step($urandom_range(0, 6));
    end
    step(RT + 10);
    modelAdvance(cyc);
    checkOutput("rx_word_random_final", rx_data, mWord);
    step(2);
    compareQueues();

    // Reset mid-TX after the 2nd strobe
    obsTx.delete();
    waitReady();
    w = $urandom;
    startWord(w, 1'b0, c0);
    while (cyc < c0 + 12) step(1);
    rst_n = 1'b0;
    step(1);
    checkOutput("midreset_tx_ready", {31'h0, tx_ready}, 32'h1);
    checkOutput("midreset_txsend", {31'h0, spart_txsend}, 32'h0);
    checkOutput("midreset_txdata", {24'h0, spart_txdata}, 32'h0);
    checkOutput("midreset_rx_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("midreset_rx_data", rx_data, 32'h0);
    checkOutput("midreset_rx_err", {31'h0, rx_err}, 32'h0);
    rst_n = 1'b1;
    step(60);
    checkOutput("midreset_strobes_total", 32'(obsTx.size()), 32'd2);
    checkOutput("midreset_tx_ready_end", {31'h0, tx_ready}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
